// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in/serial-out stage feeding a downstream serial pattern detector.
//   Words arrive over a valid/ready handshake and leave one bit per clock on
//   o_dout. A word offered during the last-bit cycle of the current word is
//   accepted immediately, so consecutive words form a gap-free bit stream.
//   While nothing is being shifted, o_dout holds IDLE_BIT.
//
// Parameters
//   WIDTH      bits per word (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
//   IDLE_BIT   fill value on o_dout while idle
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   i_load_data   in   word to serialize
//   i_load_valid  in   i_load_data is valid this cycle
//   o_load_ready  out  word can be accepted this cycle (combinational)
//   o_dout        out  serial bit (registered)
//   o_dout_valid  out  o_dout carries a data bit rather than idle fill
//   o_word_done   out  high while the last bit of a word is on o_dout
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  output logic             o_dout,
  output logic             o_dout_valid,
  output logic             o_word_done
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PREV_CNT = CW'(WIDTH - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_shiftReg;
  logic [WIDTH-1:0] w_shifted;
  logic [CW-1:0]    r_cnt;
  logic             r_dout;
  logic             r_doutValid;
  logic             r_wordDone;
  logic             w_lastBit;
  logic             w_accept;
  logic             w_firstBit;
  logic             w_nextBit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: the last-bit cycle either chains into the next word
  // or drops back to IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = SHIFT;
      SHIFT:   if (w_lastBit) w_nextState = w_accept ? SHIFT : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Handshake decode. Ready depends only on state and count, never on
  // i_load_valid, so no combinational path runs from valid back to ready.
  always_comb begin
    w_lastBit    = (r_state == SHIFT) && (r_cnt == LAST_CNT);
    o_load_ready = (r_state == IDLE) || w_lastBit;
    w_accept     = i_load_valid && o_load_ready;
  end

  // Shift direction and the bit that will reach the output next.
  always_comb begin
    if (MSB_FIRST) begin
      w_shifted  = {r_shiftReg[WIDTH-2:0], 1'b0};
      w_firstBit = i_load_data[WIDTH-1];
      w_nextBit  = r_shiftReg[WIDTH-2];
    end else begin
      w_shifted  = {1'b0, r_shiftReg[WIDTH-1:1]};
      w_firstBit = i_load_data[0];
      w_nextBit  = r_shiftReg[1];
    end
  end

  // Datapath. The register's output-end bit always mirrors r_dout, so the
  // first bit is driven on the accepting edge itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shiftReg  <= '0;
      r_cnt       <= '0;
      r_dout      <= IDLE_BIT;
      r_doutValid <= 1'b0;
      r_wordDone  <= 1'b0;
    end else if (w_accept) begin
      r_shiftReg  <= i_load_data;
      r_cnt       <= '0;
      r_dout      <= w_firstBit;
      r_doutValid <= 1'b1;
      r_wordDone  <= 1'b0;
    end else if ((r_state == SHIFT) && !w_lastBit) begin
      r_shiftReg  <= w_shifted;
      r_cnt       <= r_cnt + 1'b1;
      r_dout      <= w_nextBit;
      r_doutValid <= 1'b1;
      r_wordDone  <= (r_cnt == PREV_CNT);
    end else begin
      r_cnt       <= '0;
      r_dout      <= IDLE_BIT;
      r_doutValid <= 1'b0;
      r_wordDone  <= 1'b0;
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_doutValid;
  assign o_word_done  = r_wordDone;

endmodule
